// File: rtl/reg_bank_pkg.sv
// Shared definitions for the multi-port register bank and its dump sequencer.
package reg_bank_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NRD_DEF    = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    STREAM = ST_STREAM,
    DONE   = ST_DONE
  } dump_state_e;

endpackage

// File: rtl/reg_bank_dump_seq.sv
// Dump sequencer: walks every bank address in order behind a valid/ready handshake.
// state  | meaning
// IDLE   | waiting for dump_start
// STREAM | dump_valid high, current beat held until dump_ready
// DONE   | one-cycle done pulse after the last beat was accepted
module reg_bank_dump_seq
  import reg_bank_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dump_start,
  input  logic              dump_ready,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic              dump_done,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  dump_state_e state, state_nxt;
  logic        load_en;

  // State, beat address and beat data registers; a beat is captured only when loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dump_addr <= '0;
      dump_data <= '0;
    end else begin
      state <= state_nxt;
      if (load_en) begin
        dump_addr <= load_addr;
        dump_data <= load_data;
      end
    end
  end

  // Next-state and beat-load decisions; the counter stops at the last address, never wraps.
  always_comb begin
    state_nxt = state;
    load_en   = 1'b0;
    load_addr = dump_addr + ADDR_W'(1);
    case (state)
      IDLE: begin
        if (dump_start) begin
          state_nxt = STREAM;
          load_en   = 1'b1;
          load_addr = '0;
        end
      end
      STREAM: begin
        if (dump_ready) begin
          if (dump_addr == LAST_ADDR) state_nxt = DONE;
          else                        load_en   = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign dump_valid = (state == STREAM);
  assign dump_done  = (state == DONE);
  assign dump_busy  = (state != IDLE);

endmodule

// File: rtl/reg_bank_multi_dump.sv
// Register bank with NRD registered read ports, one write port and a streaming dump.
// Optional macro WRITE_BYPASS_EN: same-edge reads/dump loads of the written address
// return the new write data; without it they return the old contents.
module reg_bank_multi_dump
  import reg_bank_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NRD    = NRD_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  dump_start,
  output logic                  dump_busy,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [ADDR_W-1:0]     dump_addr,
  output logic [DATA_W-1:0]     dump_data,
  output logic                  dump_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] bank [DEPTH];
  logic [DATA_W-1:0] rd_next [NRD];
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;

  // Read-port and dump-load muxes, with optional write-first forwarding.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_next[i] = bank[rd_addr[i*ADDR_W +: ADDR_W]];
`ifdef WRITE_BYPASS_EN
      if (wr_en && (wr_addr == rd_addr[i*ADDR_W +: ADDR_W])) rd_next[i] = wr_data;
`endif
    end
    load_data = bank[load_addr];
`ifdef WRITE_BYPASS_EN
    if (wr_en && (wr_addr == load_addr)) load_data = wr_data;
`endif
  end

  // Bank storage and registered read data; reset clears every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < DEPTH; j++) bank[j] <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) bank[wr_addr] <= wr_data;
      for (int i = 0; i < NRD; i++) rd_data[i*DATA_W +: DATA_W] <= rd_next[i];
    end
  end

  reg_bank_dump_seq #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_dump_seq (
    .clk        (clk),
    .rst        (rst),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_done  (dump_done),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .load_addr  (load_addr),
    .load_data  (load_data)
  );

endmodule

// File: tb/tb_reg_bank_multi_dump.sv
// Self-checking bench for reg_bank_multi_dump; expectations are queued when stimulus is driven.
module tb_reg_bank_multi_dump;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NR  = 2;
  localparam int DEP = 32;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data;
  logic           wr_en = 1'b0;
  logic [AW-1:0]  wr_addr = '0;
  logic [DW-1:0]  wr_data = '0;
  logic           dump_start = 1'b0;
  logic           dump_busy, dump_valid, dump_done;
  logic           dump_ready = 1'b0;
  logic [AW-1:0]  dump_addr;
  logic [DW-1:0]  dump_data;

  int compared   = 0;
  int mismatched = 0;

  logic [DW-1:0] rd_q[$];
  beat_t         bq[$];

  reg_bank_multi_dump #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .dump_start (dump_start),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_done  (dump_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [DW-1:0] exp;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    compared++;
    if ({rd_data, dump_valid, dump_busy, dump_done, dump_addr, dump_data} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got rd=%h v=%b b=%b d=%b a=%h dd=%h, want all zero",
               rd_data, dump_valid, dump_busy, dump_done, dump_addr, dump_data);
    end
    for (int a = 0; a < DEP; a++) begin
      rd_addr = {AW'(DEP - 1 - a), AW'(a)};
      rd_q.push_back('0);
      rd_q.push_back('0);
      tick();
      for (int p = 0; p < NR; p++) begin
        exp = rd_q.pop_front();
        compared++;
        if (rd_data[p*DW +: DW] !== exp) begin
          mismatched++;
          $display("FAIL reset_read p%0d a%0d: got %h want %h", p, a, rd_data[p*DW +: DW], exp);
        end
      end
    end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] exp;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    tick();
    wr_addr = 5'd0; wr_data = 32'h0000A5A5;
    rd_addr = {AW'(0), AW'(5)};
    rd_q.push_back(32'hDEADBEEF);
    tick();
    wr_en = 1'b0;
    exp = rd_q.pop_front();
    compared++;
    if (rd_data[0 +: DW] !== exp) begin
      mismatched++;
      $display("FAIL write_read a5: got %h want %h", rd_data[0 +: DW], exp);
    end
    rd_addr = {AW'(0), AW'(0)};
    rd_q.push_back(32'h0000A5A5);
    tick();
    exp = rd_q.pop_front();
    compared++;
    if (rd_data[DW +: DW] !== exp) begin
      mismatched++;
      $display("FAIL write_read a0: got %h want %h", rd_data[DW +: DW], exp);
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] exp;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h00001234;
    rd_addr = {AW'(5), AW'(1)};
`ifdef WRITE_BYPASS_EN
    rd_q.push_back(32'h00001234);
`else
    rd_q.push_back(32'hDEADBEEF);
`endif
    rd_q.push_back(32'h00001234);
    tick();
    wr_en = 1'b0;
    exp = rd_q.pop_front();
    compared++;
    if (rd_data[DW +: DW] !== exp) begin
      mismatched++;
      $display("FAIL bypass_same_cycle: got %h want %h", rd_data[DW +: DW], exp);
    end
    tick();
    exp = rd_q.pop_front();
    compared++;
    if (rd_data[DW +: DW] !== exp) begin
      mismatched++;
      $display("FAIL bypass_next_cycle: got %h want %h", rd_data[DW +: DW], exp);
    end
  endtask

  task automatic fill_bank();
    for (int i = 0; i < DEP; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = DW'(32'h100 + i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  // Runs one dump; toggle stalls every other cycle, abort_at >= 0 resets at that beat.
  task automatic do_dump(input bit toggle, input int abort_at, input bit zero);
    int cyc = 0, done_cnt = 0, done_cyc = -1, last_acc = -1, fall_cyc = -1;
    bq.delete();
    for (int i = 0; i < DEP; i++) begin
      beat_t b;
      b.a = AW'(i);
      b.d = zero ? '0 : DW'(32'h100 + i);
      bq.push_back(b);
    end
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    while (cyc < 300) begin
      dump_start = 1'b0;
      if (abort_at >= 0 && dump_valid && int'(dump_addr) == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        compared++;
        if ({dump_valid, dump_busy, dump_done} !== 3'b000) begin
          mismatched++;
          $display("FAIL abort_flags: got v/b/d=%b%b%b want 000", dump_valid, dump_busy, dump_done);
        end
        tick();
        compared++;
        if (dump_done !== 1'b0) begin
          mismatched++;
          $display("FAIL abort_no_done: got %b want 0", dump_done);
        end
        bq.delete();
        return;
      end
      if (dump_done) begin
        done_cnt++;
        done_cyc = cyc;
        compared++;
        if (dump_valid !== 1'b0 || dump_busy !== 1'b1) begin
          mismatched++;
          $display("FAIL done_cycle_flags: got v=%b b=%b want v=0 b=1", dump_valid, dump_busy);
        end
        dump_start = 1'b1;
      end else if (done_cnt > 0) begin
        fall_cyc = cyc;
        compared++;
        if ({dump_valid, dump_busy} !== 2'b00) begin
          mismatched++;
          $display("FAIL after_done: got v=%b b=%b want 0 0", dump_valid, dump_busy);
        end
        break;
      end
      if (dump_valid) begin
        compared++;
        if (bq.size() == 0) begin
          mismatched++;
          $display("FAIL extra_beat: got addr %h with none expected", dump_addr);
        end else if (dump_addr !== bq[0].a || dump_data !== bq[0].d || dump_busy !== 1'b1) begin
          mismatched++;
          $display("FAIL beat: got a=%h d=%h b=%b want a=%h d=%h b=1",
                   dump_addr, dump_data, dump_busy, bq[0].a, bq[0].d);
        end
        dump_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
        if (dump_ready && bq.size() > 0) begin
          void'(bq.pop_front());
          last_acc = cyc;
        end
      end
      tick();
      cyc++;
    end
    dump_start = 1'b0;
    dump_ready = 1'b0;
    compared++;
    if (fall_cyc < 0 || bq.size() != 0 || done_cnt != 1 || done_cyc != last_acc + 1 ||
        fall_cyc != done_cyc + 1) begin
      mismatched++;
      $display("FAIL dump_summary: got left=%0d done=%0d done_cyc=%0d last=%0d fall=%0d want 0 1 last+1 done+1",
               bq.size(), done_cnt, done_cyc, last_acc, fall_cyc);
    end
    tick();
    compared++;
    if ({dump_valid, dump_busy} !== 2'b00) begin
      mismatched++;
      $display("FAIL start_in_done_ignored: got v=%b b=%b want 0 0", dump_valid, dump_busy);
    end
  endtask

  task automatic test_dump_stream();
    fill_bank();
    do_dump(1'b0, -1, 1'b0);
  endtask

  task automatic test_dump_stall();
    do_dump(1'b1, -1, 1'b0);
  endtask

  task automatic test_reset_mid_dump();
    logic [DW-1:0] exp;
    do_dump(1'b0, 10, 1'b0);
    for (int a = 0; a < DEP; a++) begin
      rd_addr = {AW'(a), AW'(a)};
      rd_q.push_back('0);
      tick();
      exp = rd_q.pop_front();
      compared++;
      if (rd_data[0 +: DW] !== exp || rd_data[DW +: DW] !== exp) begin
        mismatched++;
        $display("FAIL bank_after_abort a%0d: got %h want %h", a, rd_data, exp);
      end
    end
    do_dump(1'b0, -1, 1'b1);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write_read();
    test_bypass();
    test_dump_stream();
    test_dump_stall();
    test_reset_mid_dump();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
